// File: rtl/multi_fifo_to_axis.sv
// multi_fifo_to_axis
// Several first-word-fall-through packet queues merged onto one AXI4-Stream
// master port. Each queue carries packets as one header word (tuser in the
// low data bits) followed by one or more beat words. A round-robin arbiter
// picks a queue, consumes its header and then streams that queue's beats
// until the word flagged "last" has been handed off.
//
// Optional feature: define MULTI_FIFO_PKT_CNT_EN to add the pkt_count output,
// a 32-bit wrapping count of completed packets per queue.
//
// Word layout on fifo_din (per queue, W bits):
//   [DW-1:0]         data
//   [DW+DW/8-1:DW]   strb
//   [W-1]            last

module multi_fifo_to_axis #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 4,
  parameter int FIFO_DEPTH_BITS      = 4
) (
  input  logic                                   axi_aclk,
  input  logic                                   axi_aresetn,
  input  logic                                   sw_rst,
  input  logic [NUM_QUEUES-1:0]                  fifo_wr_en,
  input  logic [NUM_QUEUES*(C_M_AXIS_DATA_WIDTH+C_M_AXIS_DATA_WIDTH/8+1)-1:0] fifo_din,
  output logic [NUM_QUEUES-1:0]                  fifo_full,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]       m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]        m_axis_tuser,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast
`ifdef MULTI_FIFO_PKT_CNT_EN
  ,
  output logic [NUM_QUEUES*32-1:0]               pkt_count
`endif
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int DW    = C_M_AXIS_DATA_WIDTH;
  localparam int SW    = C_M_AXIS_DATA_WIDTH / 8;
  localparam int TUW   = C_M_AXIS_TUSER_WIDTH;
  localparam int W     = DW + SW + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = FIFO_DEPTH_BITS + 1;
  localparam int GW    = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

  localparam logic [GW-1:0] LAST_Q = GW'(NUM_QUEUES - 1);

  typedef enum logic {
    IDLE = 1'b0,  // waiting for any queue to hold a header
    PKT  = 1'b1   // streaming beats of the granted queue
  } state_t;

  // Hard reset and soft reset behave identically; both are synchronous.
  logic rst_active;
  assign rst_active = !axi_aresetn || sw_rst;

  // ---------------------------------------------------------------------------
  // Per-queue FWFT FIFOs
  // ---------------------------------------------------------------------------
  logic [W-1:0]          head [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] empty;
  logic [NUM_QUEUES-1:0] full_raw;
  logic [NUM_QUEUES-1:0] pop;

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
    logic [W-1:0]               mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
    logic [CW-1:0]              count;
    logic                       do_wr;

    // A write into a full queue is dropped even if a pop frees space this cycle.
    assign do_wr = fifo_wr_en[q] && !full_raw[q];

    // Storage write port.
    // NOTE: the storage array is deliberately not reset; flushing is done by
    // resetting the pointers, so stale contents are never observable.
    always_ff @(posedge axi_aclk) begin
      if (do_wr) begin
        mem[wr_ptr] <= fifo_din[W*q +: W];
      end
    end

    // Pointer and occupancy bookkeeping; reset flushes the queue.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge axi_aclk) begin
      if (rst_active) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_wr) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop[q]) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(do_wr) - CW'(pop[q]);
      end
    end

    // Head of queue is read combinationally: a word is visible the cycle
    // after it was written.
    assign head[q]     = mem[rd_ptr];
    assign empty[q]    = (count == '0);
    assign full_raw[q] = (count == CW'(DEPTH));
  end

  // ---------------------------------------------------------------------------
  // Arbiter / packet FSM
  // ---------------------------------------------------------------------------
  state_t          state, state_nxt;
  logic [GW-1:0]   grant, grant_nxt;
  logic [GW-1:0]   last_grant, last_grant_nxt;
  logic [TUW-1:0]  tuser_q, tuser_nxt;

  logic            rr_found;
  logic [GW-1:0]   rr_idx;
  logic [GW-1:0]   rr_cand;
  logic            beat_xfer;
  logic            beat_is_last;

  // Round-robin search: first non-empty queue after the last one served.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      rr_cand = GW'((int'(last_grant) + i) % NUM_QUEUES);
      if (!rr_found && !empty[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Beat presented whenever the granted queue has a word; reset forces it low.
  assign m_axis_tvalid = (state == PKT) && !empty[grant] && !rst_active;
  assign beat_xfer     = m_axis_tvalid && m_axis_tready;
  assign beat_is_last  = head[grant][W-1];

  // Next-state, grant bookkeeping and FIFO pop generation.
  // NOTE: every signal written here gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    tuser_nxt      = tuser_q;
    pop            = '0;
    unique case (state)
      IDLE: begin
        if (rr_found) begin
          // Header is consumed internally and never appears on the stream.
          pop[rr_idx] = 1'b1;
          grant_nxt   = rr_idx;
          tuser_nxt   = head[rr_idx][TUW-1:0];
          state_nxt   = PKT;
        end
      end
      PKT: begin
        if (beat_xfer) begin
          pop[grant] = 1'b1;
          if (beat_is_last) begin
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM and captured-header registers.
  always_ff @(posedge axi_aclk) begin
    if (rst_active) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_Q;
      tuser_q    <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      tuser_q    <= tuser_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  // Data and strobe come straight from the granted head, so they stay stable
  // during a stall: only a pop can move the head.
  assign m_axis_tdata = head[grant][DW-1:0];
  assign m_axis_tstrb = head[grant][DW+SW-1:DW];
  assign m_axis_tuser = tuser_q;
  assign m_axis_tlast = m_axis_tvalid && beat_is_last;

  assign fifo_full = full_raw & {NUM_QUEUES{!rst_active}};

`ifdef MULTI_FIFO_PKT_CNT_EN
  // ---------------------------------------------------------------------------
  // Completed-packet counters
  // ---------------------------------------------------------------------------
  logic [31:0] pkt_cnt [NUM_QUEUES];

  // Count each tlast handshake against the queue that supplied it.
  always_ff @(posedge axi_aclk) begin
    if (rst_active) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        pkt_cnt[q] <= '0;
      end
    end else if (beat_xfer && beat_is_last) begin
      pkt_cnt[grant] <= pkt_cnt[grant] + 32'd1;
    end
  end

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_pkt_count
    assign pkt_count[32*q +: 32] = pkt_cnt[q];
  end
`endif

endmodule

// File: tb/tb_multi_fifo_to_axis.sv
// tb_multi_fifo_to_axis
// Scoreboard bench for multi_fifo_to_axis. Stimulus tasks build packets,
// predict the output stream from the round-robin rule at packet level and
// push expected beats into a queue; a negedge monitor pops and compares on
// every handshake and checks that stalled beats hold.

module tb_multi_fifo_to_axis;

  localparam int DW    = 256;
  localparam int TUW   = 128;
  localparam int NQ    = 4;
  localparam int FDB   = 4;
  localparam int SW    = DW / 8;
  localparam int W     = DW + SW + 1;
  localparam int DEPTH = 1 << FDB;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn;
  logic              sw_rst;
  logic [NQ-1:0]     fifo_wr_en;
  logic [NQ*W-1:0]   fifo_din;
  logic [NQ-1:0]     fifo_full;
  logic [DW-1:0]     m_axis_tdata;
  logic [SW-1:0]     m_axis_tstrb;
  logic [TUW-1:0]    m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
`ifdef MULTI_FIFO_PKT_CNT_EN
  logic [NQ*32-1:0]  pkt_count;
`endif

  multi_fifo_to_axis #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(TUW),
    .NUM_QUEUES          (NQ),
    .FIFO_DEPTH_BITS     (FDB)
  ) dut (
    .axi_aclk     (axi_aclk),
    .axi_aresetn  (axi_aresetn),
    .sw_rst       (sw_rst),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .fifo_full    (fifo_full),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tstrb (m_axis_tstrb),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
`ifdef MULTI_FIFO_PKT_CNT_EN
    ,
    .pkt_count    (pkt_count)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [DW-1:0]  data;
    logic [SW-1:0]  strb;
    logic           last;
    logic [TUW-1:0] user;
  } beat_t;

  beat_t        sb [$];          // expected AXIS beats, in order
  logic [W-1:0] pk [NQ][$];      // words to write per queue this phase
  beat_t        exp_q [NQ][$];   // expected beats per queue this phase
  int           model_lg;        // queue served most recently
  int           model_cnt [NQ];  // completed packets per queue since reset

  int  n_checks = 0;
  int  n_errors = 0;
  bit  ready_rand = 1'b0;
  bit  ready_hold = 1'b1;
  bit  ready_pat [$];

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  // One clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge axi_aclk);
    #1;
    if (ready_pat.size() != 0) m_axis_tready = ready_pat.pop_front();
    else if (ready_rand)       m_axis_tready = ($urandom_range(0, 3) != 0);
    else                       m_axis_tready = ready_hold;
  endtask

  task automatic model_reset();
    model_lg = NQ - 1;
    for (int q = 0; q < NQ; q++) model_cnt[q] = 0;
  endtask

  // Append a header and nbeats beats to queue q, with matching expectations.
  task automatic build_pkt(input int q, input int nbeats, input logic [TUW-1:0] tu);
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    beat_t         e;
    d = rand_data();
    d[TUW-1:0] = tu;
    s = SW'($urandom());
    pk[q].push_back({1'($urandom_range(0, 1)), s, d});  // header strb/last are don't-care
    for (int b = 0; b < nbeats; b++) begin
      e.data = rand_data();
      e.strb = SW'($urandom());
      e.last = (b == nbeats - 1);
      if (e.last && $urandom_range(0, 1) == 1) e.strb = '1;
      e.user = tu;
      pk[q].push_back({e.last, e.strb, e.data});
      exp_q[q].push_back(e);
    end
  endtask

  task automatic clear_phase();
    for (int q = 0; q < NQ; q++) begin
      pk[q].delete();
      exp_q[q].delete();
    end
  endtask

  // Packets whose headers arrive together are served in rotation starting
  // after the queue served last.
  task automatic schedule(input logic [NQ-1:0] mask);
    int start;
    int q;
    start = (model_lg + 1) % NQ;
    for (int i = 0; i < NQ; i++) begin
      q = (start + i) % NQ;
      if (mask[q] && exp_q[q].size() != 0) begin
        foreach (exp_q[q][k]) sb.push_back(exp_q[q][k]);
        model_lg = q;
        model_cnt[q]++;
      end
    end
  endtask

  // Write the prepared words, one word per queue per cycle, all queues in step.
  task automatic write_all();
    int maxlen = 0;
    for (int q = 0; q < NQ; q++) if (pk[q].size() > maxlen) maxlen = pk[q].size();
    for (int k = 0; k < maxlen; k++) begin
      fifo_wr_en = '0;
      for (int q = 0; q < NQ; q++) begin
        if (k < pk[q].size()) begin
          fifo_wr_en[q] = 1'b1;
          fifo_din[W*q +: W] = pk[q][k];
        end
      end
      tick();
    end
    fifo_wr_en = '0;
  endtask

  task automatic write_q(input int q, input logic [W-1:0] w);
    fifo_wr_en = '0;
    fifo_wr_en[q] = 1'b1;
    fifo_din[W*q +: W] = w;
    tick();
    fifo_wr_en = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      tick();
      t++;
    end
    check("drain_all_beats_seen", sb.size(), 0);
    sb.delete();
    repeat (3) tick();
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!m_axis_tvalid && t < 100) begin
      tick();
      t++;
    end
    check(name, m_axis_tvalid, 1);
  endtask

  task automatic check_counts(input string name);
`ifdef MULTI_FIFO_PKT_CNT_EN
    for (int q = 0; q < NQ; q++) check(name, pkt_count[32*q +: 32], model_cnt[q]);
`else
    if (name.len() == 0) n_checks += 0;
`endif
  endtask

  task automatic run_random_phase(input logic [NQ-1:0] mask, input int maxb);
    clear_phase();
    for (int q = 0; q < NQ; q++)
      if (mask[q]) build_pkt(q, $urandom_range(1, maxb), TUW'({$urandom(), $urandom(), $urandom(), $urandom()}));
    schedule(mask);
    write_all();
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares each handshake against the scoreboard, checks stalls.
  // ---------------------------------------------------------------------------
  beat_t prev;
  bit    prev_stall = 1'b0;

  always @(negedge axi_aclk) begin
    beat_t e;
    if (!axi_aresetn || sw_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tuser},
              {1'b1, prev.data, prev.strb, prev.last, prev.user});
      if (!m_axis_tvalid && m_axis_tlast) check("tlast_without_tvalid", m_axis_tlast, 0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("beat_tdata", m_axis_tdata, e.data);
          check("beat_tstrb", m_axis_tstrb, e.strb);
          check("beat_tlast", m_axis_tlast, e.last);
          check("beat_tuser", m_axis_tuser, e.user);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev.data  = m_axis_tdata;
      prev.strb  = m_axis_tstrb;
      prev.last  = m_axis_tlast;
      prev.user  = m_axis_tuser;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout got=1 exp=0");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0]  w;
    logic [W-1:0]  word_x;
    beat_t         e;
    logic [TUW-1:0] tu0, tu1;
    int            t;

    axi_aresetn   = 1'b0;
    sw_rst        = 1'b0;
    fifo_wr_en    = '0;
    fifo_din      = '0;
    m_axis_tready = 1'b0;
    model_reset();

    repeat (3) tick();
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_fifo_full", fifo_full, 0);
    axi_aresetn = 1'b1;
    tick();
    check("post_rst_tvalid", m_axis_tvalid, 0);
    check("post_rst_fifo_full", fifo_full, 0);
    check_counts("rst_pkt_count");

    // Single 2-beat packet on queue 0 with tuser 0xA5.
    clear_phase();
    build_pkt(0, 2, TUW'(8'hA5));
    schedule(4'b0001);
    write_all();
    drain();
    check("idle_after_pkt_tvalid", m_axis_tvalid, 0);

    // Soft reset returns the rotation pointer to the last queue.
    sw_rst = 1'b1;
    #1;
    check("sw_rst_fifo_full", fifo_full, 0);
    tick();
    sw_rst = 1'b0;
    model_reset();
    check_counts("sw_rst_pkt_count");

    // All four queues at once, then again: rotation 0,1,2,3 then 0 first.
    clear_phase();
    for (int q = 0; q < NQ; q++) build_pkt(q, 2, TUW'(q + 16));
    schedule(4'hF);
    write_all();
    drain();
    run_random_phase(4'hF, 3);

    // Stall pattern 1,0,0,1 on a 3-beat packet.
    ready_hold = 1'b0;
    clear_phase();
    build_pkt(2, 3, TUW'(32'h0BAD_F00D));
    schedule(4'b0100);
    write_all();
    wait_valid("stall_test_valid");
    m_axis_tready = 1'b1;
    ready_pat = '{1'b0, 1'b0, 1'b1};
    ready_hold = 1'b1;
    drain();

    // Fill queue 1 while queue 0 holds the output stalled.
    ready_hold = 1'b0;
    m_axis_tready = 1'b0;
    tu0 = TUW'(32'h1111);
    tu1 = TUW'(32'h2222);
    clear_phase();
    build_pkt(0, 1, tu0);
    schedule(4'b0001);
    write_all();
    wait_valid("full_test_q0_valid");
    w = {1'b0, SW'($urandom()), rand_data()};
    w[TUW-1:0] = tu1;
    write_q(1, w);
    for (int k = 1; k < DEPTH; k++) begin
      e.data = rand_data();
      e.strb = SW'($urandom());
      e.last = 1'b0;
      e.user = tu1;
      sb.push_back(e);
      write_q(1, {e.last, e.strb, e.data});
      if (k == DEPTH - 2) check("full_before_16th", fifo_full[1], 0);
      if (k == DEPTH - 1) check("full_after_16th", fifo_full[1], 1);
    end
    word_x = {1'b1, SW'($urandom()), rand_data()};
    write_q(1, word_x);
    check("full_after_17th", fifo_full[1], 1);
    check("full_other_queues", fifo_full & 4'b1101, 0);
    e.data = rand_data();
    e.strb = '1;
    e.last = 1'b1;
    e.user = tu1;
    sb.push_back(e);
    model_lg = 1;
    model_cnt[1]++;
    ready_hold = 1'b1;
    m_axis_tready = 1'b1;
    t = 0;
    while (sb.size() > 1 && t < 3000) begin
      tick();
      t++;
    end
    check("full_test_15_beats_out", sb.size(), 1);
    write_q(1, {e.last, e.strb, e.data});
    drain();

    // Randomized packets with random back-pressure.
    ready_rand = 1'b1;
    for (int p = 0; p < 30; p++) run_random_phase(NQ'($urandom_range(1, (1 << NQ) - 1)), 6);
    ready_rand = 1'b0;
    ready_hold = 1'b1;
    check_counts("random_pkt_count");

    // Hard reset after the first beat of a 4-beat packet.
    ready_hold = 1'b0;
    m_axis_tready = 1'b0;
    clear_phase();
    build_pkt(3, 4, TUW'(32'h4444));
    write_all();
    wait_valid("rst_mid_valid");
    sb.push_back(exp_q[3][0]);
    m_axis_tready = 1'b1;
    tick();
    axi_aresetn = 1'b0;
    #1;
    check("rst_mid_tvalid_during", m_axis_tvalid, 0);
    check("rst_mid_full_during", fifo_full, 0);
    tick();
    axi_aresetn = 1'b1;
    model_reset();
    check("rst_mid_beats_seen", sb.size(), 0);
    check("rst_mid_tvalid_after", m_axis_tvalid, 0);
    check("rst_mid_tlast_after", m_axis_tlast, 0);
    check("rst_mid_full_after", fifo_full, 0);
    tick();
    check("rst_mid_still_empty", m_axis_tvalid, 0);
    ready_hold = 1'b1;

    // Packet counts: three on queue 2, one on queue 0.
    run_random_phase(4'b0101, 4);
    run_random_phase(4'b0100, 4);
    run_random_phase(4'b0100, 4);
    check_counts("final_pkt_count");

    check("final_scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_fifo_to_axis.md
MULTI_FIFO_TO_AXIS -- requirements
Module: multi_fifo_to_axis

Interface
REQ-001 The block SHALL expose parameter C_M_AXIS_DATA_WIDTH, default 256, AXIS data width in bits (multiple of 8).
REQ-002 The block SHALL expose parameter C_M_AXIS_TUSER_WIDTH, default 128, AXIS tuser width (must not exceed C_M_AXIS_DATA_WIDTH).
REQ-003 The block SHALL expose parameter NUM_QUEUES, default 4, number of input queues (1..8).
REQ-004 The block SHALL expose parameter FIFO_DEPTH_BITS, default 4, log2 of per-queue FIFO depth.
REQ-005 The block SHALL have ports: axi_aclk  in  1  sole clock; axi_aresetn  in  1  reset, synchronous, active-low.
REQ-006 The block SHALL have ports: sw_rst  in  1  synchronous active-high soft reset; fifo_wr_en  in  NUM_QUEUES  per-queue write strobe.
REQ-007 The block SHALL have port fifo_din  in  NUM_QUEUES*W, where W = C_M_AXIS_DATA_WIDTH + C_M_AXIS_DATA_WIDTH/8 + 1; queue q occupies slice [W*(q+1)-1 : W*q].
REQ-008 The block SHALL have ports: fifo_full  out  NUM_QUEUES  per-queue full flag; m_axis_tdata/tstrb/tuser/tvalid/tlast  out; m_axis_tready  in.
REQ-009 Each W-bit word SHALL be packed as: bits [DW-1:0] data, [DW+DW/8-1:DW] strb, bit [W-1] last.

Function
REQ-010 Each queue SHALL be a single-clock first-word-fall-through FIFO of 2**FIFO_DEPTH_BITS words; a written word is visible at the head one cycle after the write.
REQ-011 A write while fifo_full[q]=1 SHALL be dropped, even if the same queue is popped in that cycle.
REQ-012 Per packet, a queue SHALL carry one header word (tuser in data[C_M_AXIS_TUSER_WIDTH-1:0]; strb/last ignored) followed by one or more beat words.
REQ-013 States: IDLE, PKT; the FSM SHALL reset to IDLE with last_grant = NUM_QUEUES-1.
REQ-014 In IDLE, if any queue is non-empty, the FSM SHALL grant the first non-empty queue searching from (last_grant+1) mod NUM_QUEUES upward with wrap, pop its header word, register its tuser, and enter PKT.
REQ-015 In PKT, m_axis_tvalid SHALL equal !empty[grant]; tdata/tstrb SHALL equal the granted head word; m_axis_tlast SHALL equal its last bit; m_axis_tuser SHALL equal the registered tuser.
REQ-016 In PKT, a word SHALL be popped only on tvalid && tready; on a popped word with last=1 the FSM SHALL set last_grant = grant and return to IDLE.
REQ-017 While tvalid=1 and tready=0, all m_axis outputs SHALL hold stable; tvalid SHALL never drop without a handshake.
REQ-018 In IDLE, m_axis_tvalid and m_axis_tlast SHALL be 0; a header pop SHALL never be emitted on AXIS.
REQ-019 Non-granted queues SHALL keep accepting writes while another queue is in PKT; no packet interleaving SHALL occur.
REQ-020 The strb field SHALL be passed through unchanged; tlast SHALL derive only from the last bit (a full-strb last beat is legal).

Reset
REQ-021 On axi_aresetn=0 or sw_rst=1 at a clock edge, all FIFOs SHALL be flushed, state SHALL be IDLE, tuser register SHALL be 0, last_grant SHALL be NUM_QUEUES-1.
REQ-022 During and the cycle after reset, m_axis_tvalid, m_axis_tlast and fifo_full SHALL be 0; a packet interrupted mid-transfer SHALL be discarded without tlast.

Configuration
REQ-023 With MULTI_FIFO_PKT_CNT_EN defined, the block SHALL add output pkt_count  out  NUM_QUEUES*32, slice q incrementing by 1 on each tlast handshake from queue q, wrapping at 2**32, cleared by reset/sw_rst.
REQ-024 Without MULTI_FIFO_PKT_CNT_EN, the pkt_count port and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-025 Single queue 0: header tuser=0xA5, beats D0,D1(last=1), tready=1 -> two AXIS beats, tuser=0xA5 on both, tlast on D1 only, FSM back to IDLE.
REQ-026 Queues 0..3 each hold one 2-beat packet at once -> output order 0,1,2,3; then a new packet on queue 0 is granted next.
REQ-027 tready toggling 1,0,0,1 during 3-beat packet -> tdata stable while stalled, exactly 3 handshakes, no beat lost or duplicated.
REQ-028 Write 17 words into a 16-deep queue with no reads -> fifo_full=1 after 16th, 17th dropped, 16 words later read out intact.
REQ-029 Assert axi_aresetn=0 for one cycle after beat 1 of a 4-beat packet -> tvalid=0 next cycle, FIFOs empty, next packet starts with a header.
REQ-030 With MULTI_FIFO_PKT_CNT_EN: 3 packets on queue 2, 1 on queue 0 -> pkt_count slice 2 = 3, slice 0 = 1, others 0.
